// File: rtl/clk_gen_pkg.sv
// Shared constants and state encoding for the ring-oscillator stage calibrator.
package clk_gen_pkg;

  localparam int SEL_W      = 4;
  localparam int NUM_STAGES = 1 << SEL_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    DECIDE  = 3'd3,
    DONE    = 3'd4
  } cal_state_t;

endpackage

// File: rtl/clk_gen_stage_calibrator_if.sv
// Control/status and oscillator-side signals of the stage calibrator.
interface clk_gen_stage_calibrator_if import clk_gen_pkg::*; #(
  parameter int CNT_W = 12
);
  logic             start;
  logic [CNT_W-1:0] target_count;
  logic             osc_in;
  logic             osc_enable;
  logic [SEL_W-1:0] stage_sel;
  logic             busy;
  logic             done;
  logic             locked;
  logic [CNT_W-1:0] meas_count;
  logic             overflow;

  modport master (
    output start, target_count, osc_in,
    input  osc_enable, stage_sel, busy, done, locked, meas_count, overflow
  );

  modport slave (
    input  start, target_count, osc_in,
    output osc_enable, stage_sel, busy, done, locked, meas_count, overflow
  );
endinterface

// File: rtl/clk_gen_edge_counter.sv
// Synchronizes the divided oscillator, detects rising edges and counts them
// with saturation; overflow flags an edge that arrived with the counter full.
module clk_gen_edge_counter #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_osc,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_hist;
  logic             w_rise;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  assign w_rise = r_sync2 & ~r_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_sync1 <= i_osc;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (i_clr) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (i_en && w_rise) begin
        // Hold at all-ones rather than wrap so a fast stage still reads as fast.
        if (&r_count) r_ovf   <= 1'b1;
        else          r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/clk_gen_stage_calibrator.sv
// Closed-loop SAR calibration of the ring-oscillator stage select: settle,
// count edges over a fixed window, decide one bit per trial, then verify.
module clk_gen_stage_calibrator import clk_gen_pkg::*; #(
  parameter int CNT_W      = 12,
  parameter int WINDOW_CYC = 1024,
  parameter int SETTLE_CYC = 64,
  parameter int TOL        = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  clk_gen_stage_calibrator_if.slave   bus
);

  localparam int TMR_MAX = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYC - 1);
  localparam logic [SEL_W-1:0] SEL_MID     = SEL_W'(NUM_STAGES / 2);
  localparam logic [CNT_W:0]   TOL_V       = (CNT_W+1)'(TOL);

  cal_state_t       r_state;
  logic [TMR_W-1:0] r_timer;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_mask;
  logic             r_verify;
  logic [CNT_W-1:0] r_target;
  logic             r_en;
  logic             r_busy;
  logic             r_done;
  logic             r_locked;
  logic [CNT_W-1:0] r_meas;
  logic             r_ovf;

  logic [CNT_W-1:0]   w_cnt;
  logic               w_cnt_ovf;
  logic signed [CNT_W:0] w_diff;
  logic [CNT_W:0]     w_adiff;
  logic               w_in_tol;
  logic [SEL_W-1:0]   w_sel_next;

  clk_gen_edge_counter #(.CNT_W(CNT_W)) u_edge_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_osc   (bus.osc_in),
    .i_clr   (r_state == SETTLE),
    .i_en    (r_state == MEASURE),
    .o_count (w_cnt),
    .o_ovf   (w_cnt_ovf)
  );

  assign w_diff   = $signed({1'b0, w_cnt}) - $signed({1'b0, r_target});
  assign w_adiff  = w_diff[CNT_W] ? unsigned'(-w_diff) : unsigned'(w_diff);
  assign w_in_tol = (w_adiff <= TOL_V) && !w_cnt_ovf;

  // Too fast keeps the trial bit (more stages); a tie drops it toward the faster tap.
  assign w_sel_next = ((w_cnt > r_target) ? r_sel : (r_sel & ~r_mask)) | (r_mask >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_sel    <= '0;
      r_mask   <= '0;
      r_verify <= 1'b0;
      r_target <= '0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_locked <= 1'b0;
      r_meas   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_target <= bus.target_count;
            r_sel    <= SEL_MID;
            r_mask   <= SEL_MID;
            r_verify <= 1'b0;
            r_en     <= 1'b1;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_locked <= 1'b0;
            r_timer  <= SETTLE_LAST;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_timer == '0) begin
            r_timer <= WINDOW_LAST;
            r_state <= MEASURE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        MEASURE: begin
          if (r_timer == '0) r_state <= DECIDE;
          else               r_timer <= r_timer - 1'b1;
        end
        DECIDE: begin
          r_meas <= w_cnt;
          r_ovf  <= w_cnt_ovf;
          if (r_verify) begin
            r_locked <= w_in_tol;
            r_en     <= w_in_tol;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            // After the LSB decision the sel is final; one more trial verifies it.
            r_sel    <= w_sel_next;
            r_mask   <= r_mask >> 1;
            r_verify <= r_mask[0];
            r_timer  <= SETTLE_LAST;
            r_state  <= SETTLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.osc_enable = r_en;
  assign bus.stage_sel  = r_sel;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.locked     = r_locked;
  assign bus.meas_count = r_meas;
  assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_clk_gen_stage_calibrator.sv
// Closed-loop bench: ring oscillator modelled with period 4+2*sel clk cycles,
// timeline-level reference model of the calibration checked every cycle.
module tb_clk_gen_stage_calibrator;

  localparam int S   = 64;
  localparam int W   = 1024;
  localparam int T   = S + W + 1;
  localparam int LAT = 5 * T + 1;
  localparam int WS  = 256;

  logic clk = 1'b0;
  logic reset;
  logic reset_s;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   sat_fin = 1'b0;

  clk_gen_stage_calibrator_if #(.CNT_W(12)) bus_m ();
  clk_gen_stage_calibrator_if #(.CNT_W(4))  bus_s ();

  clk_gen_stage_calibrator #(.CNT_W(12), .WINDOW_CYC(W), .SETTLE_CYC(S), .TOL(2)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_m));

  clk_gen_stage_calibrator #(.CNT_W(4), .WINDOW_CYC(WS), .SETTLE_CYC(S), .TOL(2)) u_sat (
    .clk(clk), .reset(reset_s), .bus(bus_s));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the calibration is a timeline of 5 trials of T cycles
  // (settle S, window W, one decision) counted from the accepting edge.
  int   m_j, m_sel, m_tgt, m_cnt, m_meas, m_d, m_p, m_k, m_b;
  bit   m_act = 1'b0, m_valid = 1'b0;
  bit   m_busy, m_done, m_lock, m_en, m_ovf, m_covf;
  logic [3:0] oh = '0;   // osc_in as sampled by the upcoming edge and the 3 before it
  int   osc_ph = 0;
  logic osc_v  = 1'b0;

  initial begin : model
    bus_m.osc_in = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid)
        chk("cycle_outputs",
            {bus_m.busy, bus_m.done, bus_m.locked, bus_m.osc_enable,
             bus_m.stage_sel, bus_m.meas_count, bus_m.overflow},
            {m_busy, m_done, m_lock, m_en, 4'(m_sel), 12'(m_meas), m_ovf});
      if (bus_m.osc_enable !== 1'b1) begin
        osc_v = 1'b0; osc_ph = 0;
      end else begin
        osc_ph++;
        if (osc_ph >= 2 + int'(bus_m.stage_sel)) begin osc_v = ~osc_v; osc_ph = 0; end
      end
      bus_m.osc_in = osc_v;
      oh = {oh[2:0], osc_v};
      // Advance the model across the upcoming edge.
      if (reset) begin
        m_act = 0; m_busy = 0; m_done = 0; m_lock = 0; m_en = 0;
        m_sel = 0; m_meas = 0; m_ovf = 0; m_valid = 1;
      end else if (m_act) begin
        m_p = m_j % T; m_k = m_j / T;
        if (m_p < S) begin
          m_cnt = 0; m_covf = 0;
        end else if (m_p < S + W) begin
          if (oh[2] && !oh[3]) begin
            if (m_cnt == 4095) m_covf = 1; else m_cnt++;
          end
        end else begin
          m_meas = m_cnt; m_ovf = m_covf;
          if (m_k < 4) begin
            m_b = 3 - m_k;
            if (!(m_cnt > m_tgt)) m_sel = m_sel & ~(1 << m_b);
            if (m_b > 0) m_sel = m_sel | (1 << (m_b - 1));
          end else begin
            m_d = m_cnt - m_tgt;
            if (m_d < 0) m_d = -m_d;
            m_lock = (m_d <= 2) && !m_covf;
            m_en = m_lock; m_busy = 0; m_done = 1; m_act = 0;
          end
        end
        m_j++;
      end else if (m_valid && bus_m.start === 1'b1) begin
        m_act = 1; m_j = 0; m_tgt = int'(bus_m.target_count); m_sel = 8;
        m_busy = 1; m_done = 0; m_lock = 0; m_en = 1;
      end
    end
  end

  task automatic run_cal(input logic [11:0] t, input bit poke, output int lat);
    @(posedge clk); #1 bus_m.start = 1'b1; bus_m.target_count = t; lat = 0;
    do begin
      @(posedge clk); #1 lat++;
      bus_m.start = poke && (lat == 700 || lat == 3100);
    end while (!bus_m.done && lat < 8000);
    bus_m.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int lat;
    logic [11:0] t;
    reset = 1'b1; bus_m.start = 1'b0; bus_m.target_count = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_osc_enable", bus_m.osc_enable, 64'd0);
    chk("rst_stage_sel", bus_m.stage_sel, 64'd0);
    chk("rst_flags", {bus_m.busy, bus_m.done, bus_m.locked, bus_m.overflow}, 64'd0);
    chk("rst_meas_count", bus_m.meas_count, 64'd0);

    // Sel 5 measures 73-74; 72 sits inside tolerance while keeping the LSB trial.
    run_cal(12'd72, 1'b0, lat);
    chk("near_exact_latency", lat, LAT);
    chk("near_exact_sel", bus_m.stage_sel, 64'd5);
    chk("near_exact_locked", bus_m.locked, 64'd1);

    run_cal(12'd4095, 1'b0, lat);
    chk("fastest_sel", bus_m.stage_sel, 64'd0);
    chk("fastest_locked", bus_m.locked, 64'd0);
    chk("fastest_count", bus_m.meas_count, 64'd256);

    run_cal(12'd0, 1'b0, lat);
    chk("slowest_sel", bus_m.stage_sel, 64'd15);
    chk("slowest_locked_done", {bus_m.locked, bus_m.done}, 64'b01);

    // Sel 2 yields exactly 128: the tie clears bit 1, the LSB trial then keeps sel 1.
    run_cal(12'd128, 1'b1, lat);
    chk("busy_start_latency", lat, LAT);
    chk("tie_sel", bus_m.stage_sel, 64'd1);
    chk("tie_locked", bus_m.locked, 64'd0);

    @(posedge clk); #1 bus_m.start = 1'b1; bus_m.target_count = 12'd100;
    @(posedge clk); #1 bus_m.start = 1'b0;
    repeat (2 * T + S + 199) @(posedge clk);
    #1 reset = 1'b1; bus_m.start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; bus_m.start = 1'b0;
    @(negedge clk);
    chk("midreset_outputs",
        {bus_m.busy, bus_m.done, bus_m.locked, bus_m.osc_enable, bus_m.stage_sel,
         bus_m.meas_count, bus_m.overflow}, 64'd0);
    @(negedge clk);
    chk("start_with_reset_ignored", bus_m.busy, 64'd0);

    run_cal(12'd100, 1'b0, lat);
    chk("recal_latency", lat, LAT);
    chk("recal_sel", bus_m.stage_sel, 64'd3);

    for (int i = 0; i < 2; i++) begin
      t = 12'($urandom_range(260, 30));
      run_cal(t, 1'($urandom_range(1, 0)), lat);
      chk("rand_latency", lat, LAT);
    end

    wait (sat_fin);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : sat_osc
    int   ph;
    logic v;
    ph = 0; v = 1'b0; bus_s.osc_in = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_s.osc_enable !== 1'b1) begin
        v = 1'b0; ph = 0;
      end else begin
        ph++;
        if (ph >= 2 + int'(bus_s.stage_sel)) begin v = ~v; ph = 0; end
      end
      bus_s.osc_in = v;
    end
  end

  initial begin : sat_test
    int lat;
    reset_s = 1'b1; bus_s.start = 1'b0; bus_s.target_count = '0;
    repeat (4) @(posedge clk);
    #1 reset_s = 1'b0;
    @(posedge clk); #1 bus_s.start = 1'b1; bus_s.target_count = 4'd15; lat = 0;
    do begin
      @(posedge clk); #1 lat++;
      bus_s.start = 1'b0;
    end while (!bus_s.done && lat < 3000);
    @(negedge clk);
    chk("sat_latency", lat, 64'(5 * (S + WS + 1) + 1));
    chk("sat_sel", bus_s.stage_sel, 64'd0);
    chk("sat_meas_count", bus_s.meas_count, 64'd15);
    chk("sat_overflow", bus_s.overflow, 64'd1);
    chk("sat_locked", bus_s.locked, 64'd0);
    sat_fin = 1'b1;
  end

endmodule
